// File: rtl/debounce_pkg.sv
// Shared types and elaboration helpers for the multi-channel debouncer.
package debounce_pkg;

   typedef struct packed {
      logic db;
      logic rise;
      logic fall;
      logic held;
   } chan_out_t;

   function automatic int unsigned ms_to_cycles(input int unsigned ms,
                                                input int unsigned clkfreq);
      return (ms * clkfreq) / 1000;
   endfunction

   // Bits needed to hold 0..cycles; never narrower than one bit.
   function automatic int unsigned ctr_width(input int unsigned cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, edge pulses.
// Optional long-press detector enabled by DEBOUNCE_HOLD_EN.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int unsigned DEB_CYC   = 10,
   parameter int unsigned HOLD_CYC  = 1000,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      pb_i,
   output chan_out_t out_o
);

   localparam int unsigned   CW       = ctr_width(DEB_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

   logic          s1_q, s2_q;
   logic          db_q, db_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // A new level must sit on s2 for DEB_CYC consecutive cycles before db follows.
   always_comb begin
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      cnt_d  = '0;
      if (s2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d   = s2_q;
            rise_d = s2_q;
            fall_d = ~s2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= RESET_VAL;
         s2_q   <= RESET_VAL;
         db_q   <= RESET_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= pb_i;
         s2_q   <= s1_q;
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         cnt_q  <= cnt_d;
      end
   end

`ifdef DEBOUNCE_HOLD_EN
   localparam int unsigned   HW       = ctr_width(HOLD_CYC);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);

   logic [HW-1:0] hcnt_q, hcnt_d;
   logic          held_q, held_d;

   if (HOLD_CYC < 1) begin : g_bad_hold
      $error("debounce_chan: HOLD_CYC must be >= 1");
   end

   // Counts cycles spent at db=1; saturates so each press yields one pulse.
   always_comb begin
      hcnt_d = '0;
      held_d = 1'b0;
      if (db_q) begin
         if (hcnt_q < HOLD_MAX) begin
            hcnt_d = hcnt_q + HW'(1);
            held_d = (hcnt_d == HOLD_MAX);
         end else begin
            hcnt_d = hcnt_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q <= '0;
         held_q <= 1'b0;
      end else begin
         hcnt_q <= hcnt_d;
         held_q <= held_d;
      end
   end

   assign out_o = '{db: db_q, rise: rise_q, fall: fall_q, held: held_q};
`else
   logic unused_hold;
   assign unused_hold = ^HOLD_CYC;

   assign out_o = '{db: db_q, rise: rise_q, fall: fall_q, held: 1'b0};
`endif

endmodule

// File: rtl/debounce_multi.sv
// NCH independent debounce channels with level, rise/fall and long-press outputs.
// Long-press detection is built only when DEBOUNCE_HOLD_EN is defined.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int unsigned NCH         = 4,
   parameter int unsigned CLKFREQ     = 1000,
   parameter int unsigned DEBOUNCE_MS = 10,
   parameter int unsigned HOLD_MS     = 1000,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] pb,
   output logic [NCH-1:0] db,
   output logic [NCH-1:0] rise,
   output logic [NCH-1:0] fall,
   output logic [NCH-1:0] held
);

   localparam int unsigned DEBOUNCE_CYC = ms_to_cycles(DEBOUNCE_MS, CLKFREQ);
   localparam int unsigned HOLD_CYC     = ms_to_cycles(HOLD_MS, CLKFREQ);

   if (DEBOUNCE_CYC < 1) begin : g_bad_deb
      $error("debounce_multi: DEBOUNCE_CYC must be >= 1");
   end
   if (NCH < 1) begin : g_bad_nch
      $error("debounce_multi: NCH must be >= 1");
   end

   for (genvar i = 0; i < int'(NCH); i++) begin : g_chan
      chan_out_t ch;

      debounce_chan #(
         .DEB_CYC   (DEBOUNCE_CYC),
         .HOLD_CYC  (HOLD_CYC),
         .RESET_VAL (RESET_VAL)
      ) u_chan (
         .clk   (clk),
         .rst_n (rst_n),
         .pb_i  (pb[i]),
         .out_o (ch)
      );

      assign db[i]   = ch.db;
      assign rise[i] = ch.rise;
      assign fall[i] = ch.fall;
      assign held[i] = ch.held;
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios plus randomized
// traffic against a sliding-window reference model.
module tb_debounce_multi;

   localparam int unsigned NCH         = 4;
   localparam int unsigned CLKFREQ     = 1000;
   localparam int unsigned DEBOUNCE_MS = 10;
   localparam int unsigned HOLD_MS     = 50;
   localparam int          CYC         = 10;
   localparam int          HOLD        = 50;
   localparam logic        RESET_VAL   = 1'b0;
`ifdef DEBOUNCE_HOLD_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic           clk;
   logic           rst_n;
   logic [NCH-1:0] pb, db, rise, fall, held;

   debounce_multi #(
      .NCH         (NCH),
      .CLKFREQ     (CLKFREQ),
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .HOLD_MS     (HOLD_MS),
      .RESET_VAL   (RESET_VAL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pb    (pb),
      .db    (db),
      .rise  (rise),
      .fall  (fall),
      .held  (held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: hist[0] is the pin value sampled at the latest edge.
   logic [NCH-1:0] hist[$];
   logic [NCH-1:0] exp_db, exp_rise, exp_fall, exp_held;
   int             run_len[NCH];

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < CYC + 2; k++) hist.push_back({NCH{RESET_VAL}});
      exp_db   = {NCH{RESET_VAL}};
      exp_rise = '0;
      exp_fall = '0;
      exp_held = '0;
      for (int c = 0; c < int'(NCH); c++) run_len[c] = 0;
   endtask

   // Advance one clock; db adopts a level once the synchronised pin has shown it
   // for CYC consecutive cycles (pin samples two to CYC+1 edges old).
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         hist.push_front(pb);
         void'(hist.pop_back());
         exp_rise = '0;
         exp_fall = '0;
         for (int c = 0; c < int'(NCH); c++) begin
            logic v;
            bit   stable;
            v      = hist[2][c];
            stable = 1'b1;
            for (int k = 3; k < CYC + 2; k++) if (hist[k][c] !== v) stable = 1'b0;
            exp_held[c] = HOLD_EN && (run_len[c] == HOLD);
            if (stable && (v !== exp_db[c])) begin
               exp_db[c] = v;
               if (v) exp_rise[c] = 1'b1;
               else   exp_fall[c] = 1'b1;
            end
            if (exp_db[c]) run_len[c] = (run_len[c] > HOLD) ? run_len[c] : run_len[c] + 1;
            else           run_len[c] = 0;
         end
      end
      #1;
   endtask

   task automatic settle(input logic [NCH-1:0] val);
      pb = val;
      repeat (CYC + 4) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pb    = '1;
      repeat (3) tick();
      n_checks++;
      if ({db, rise, fall, held} !== {{NCH{RESET_VAL}}, {3*NCH{1'b0}}})
         $display("FAIL reset_state: got db=%b r=%b f=%b h=%b want db=%b r/f/h=0",
                  db, rise, fall, held, {NCH{RESET_VAL}});
      else n_pass++;
      rst_n = 1'b1;
      for (int j = 1; j <= 13; j++) begin
         tick();
         n_checks++;
         if (db !== ((j >= 12) ? 4'b1111 : 4'b0000) || rise !== ((j == 12) ? 4'b1111 : 4'b0000)
             || fall !== 4'b0000)
            $display("FAIL reset_release edge %0d: got db=%b r=%b f=%b", j, db, rise, fall);
         else n_pass++;
      end
   endtask

   task automatic test_clean_press();
      settle('0);
      pb[0] = 1'b1;
      for (int j = 0; j <= 12; j++) begin
         tick();
         n_checks++;
         if (db !== ((j >= 11) ? 4'b0001 : 4'b0000) || rise !== ((j == 11) ? 4'b0001 : 4'b0000))
            $display("FAIL clean_press edge %0d: got db=%b r=%b", j, db, rise);
         else n_pass++;
      end
   endtask

   task automatic test_bounce();
      int rises;
      settle('0);
      pb[1] = 1'b1;
      for (int c = 0; c < 30; c++) begin
         tick();
         n_checks++;
         if (db !== 4'b0000 || rise !== 4'b0000)
            $display("FAIL bounce_hold cyc %0d: got db=%b r=%b want 0", c, db, rise);
         else n_pass++;
         if (c % 3 == 2) pb[1] = ~pb[1];
      end
      rises = 0;
      for (int j = 0; j <= 14; j++) begin
         tick();
         if (rise[1]) rises++;
         n_checks++;
         if (db !== ((j >= 11) ? 4'b0010 : 4'b0000))
            $display("FAIL bounce_settle edge %0d: got db=%b", j, db);
         else n_pass++;
      end
      n_checks++;
      if (rises !== 1) $display("FAIL bounce_rise_count: got %0d want 1", rises);
      else n_pass++;
   endtask

   task automatic test_glitch();
      settle('0);
      pb[2] = 1'b1;
      for (int j = 0; j <= 30; j++) begin
         tick();
         if (j == 8) pb[2] = 1'b0;
         n_checks++;
         if (db !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000)
            $display("FAIL glitch9 edge %0d: got db=%b r=%b f=%b", j, db, rise, fall);
         else n_pass++;
      end
      pb[2] = 1'b1;
      for (int j = 0; j <= 25; j++) begin
         tick();
         if (j == 9) pb[2] = 1'b0;
         n_checks++;
         if (db !== ((j >= 11 && j < 21) ? 4'b0100 : 4'b0000)
             || rise !== ((j == 11) ? 4'b0100 : 4'b0000) || fall !== ((j == 21) ? 4'b0100 : 4'b0000))
            $display("FAIL pulse10 edge %0d: got db=%b r=%b f=%b", j, db, rise, fall);
         else n_pass++;
      end
   endtask

   task automatic test_simultaneous();
      settle(4'b0001);
      pb = 4'b1000;
      for (int j = 0; j <= 12; j++) begin
         tick();
         n_checks++;
         if (db !== ((j >= 11) ? 4'b1000 : 4'b0001) || rise !== ((j == 11) ? 4'b1000 : 4'b0000)
             || fall !== ((j == 11) ? 4'b0001 : 4'b0000))
            $display("FAIL simultaneous edge %0d: got db=%b r=%b f=%b", j, db, rise, fall);
         else n_pass++;
      end
   endtask

   task automatic test_hold();
`ifdef DEBOUNCE_HOLD_EN
      settle('0);
      pb[1] = 1'b1;
      for (int j = 0; j <= 110; j++) begin
         tick();
         if (j == 99) pb[1] = 1'b0;
         n_checks++;
         if (held !== ((j == 61) ? 4'b0010 : 4'b0000))
            $display("FAIL hold_long edge %0d: got held=%b", j, held);
         else n_pass++;
      end
      settle('0);
      pb[1] = 1'b1;
      for (int j = 0; j <= 79; j++) begin
         tick();
         if (j == 29) pb[1] = 1'b0;
         n_checks++;
         if (held !== 4'b0000) $display("FAIL hold_short edge %0d: got held=%b", j, held);
         else n_pass++;
      end
`else
      settle('1);
      for (int j = 0; j < 120; j++) begin
         tick();
         n_checks++;
         if (held !== 4'b0000) $display("FAIL held_tied cyc %0d: got held=%b", j, held);
         else n_pass++;
      end
`endif
   endtask

   task automatic test_random();
      int rem[NCH];
      for (int c = 0; c < int'(NCH); c++) rem[c] = 1;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < int'(NCH); c++) begin
            rem[c]--;
            if (rem[c] <= 0) begin
               pb[c]  = ~pb[c];
               rem[c] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(55, 80))
                                                    : int'($urandom_range(1, 14));
            end
         end
         if (n == 1500) begin
            rst_n = 1'b0;
            #1;
            n_checks++;
            if ({db, rise, fall, held} !== {{NCH{RESET_VAL}}, {3*NCH{1'b0}}})
               $display("FAIL async_reset: got db=%b r=%b f=%b h=%b", db, rise, fall, held);
            else n_pass++;
         end
         if (n == 1503) rst_n = 1'b1;
         tick();
         n_checks++;
         if ({db, rise, fall, held} !== {exp_db, exp_rise, exp_fall, exp_held})
            $display("FAIL random cyc %0d: got db=%b r=%b f=%b h=%b want db=%b r=%b f=%b h=%b",
                     n, db, rise, fall, held, exp_db, exp_rise, exp_fall, exp_held);
         else n_pass++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      pb    = '1;
      model_reset();
      test_reset();
      test_clean_press();
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_hold();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
